// File: rtl/sd_sector_streamer_pkg.sv
// Shared constants and state encodings for the SD sector streamer.
package sd_sector_streamer_pkg;
    localparam int          SECTOR_BYTES = 512;
    localparam logic [8:0]  LAST_ADDR    = 9'(SECTOR_BYTES - 1);

    typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_WAIT} fill_state_t;
    typedef enum logic       {D_IDLE, D_RUN}           drain_state_t;

    // One skid entry: byte, end-of-sector marker, end-of-request marker.
    typedef struct packed {
        logic [7:0] data;
        logic       eos;
        logic       last;
    } skid_entry_t;
endpackage

// File: rtl/sd_bank_ram.sv
// 1024x8 simple dual-port RAM: one write port, one registered read port.
module sd_bank_ram
    import sd_sector_streamer_pkg::*;
(
    input  logic       clk,
    input  logic       i_we,
    input  logic [9:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic       i_re,
    input  logic [9:0] i_raddr,
    output logic [7:0] o_rdata
);
    logic [7:0] r_mem [0:2*SECTOR_BYTES-1];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sd_sector_streamer.sv
// Streams N consecutive SD sectors through a ping-pong buffer as a valid/ready byte stream.
module sd_sector_streamer
    import sd_sector_streamer_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_start,
    input  logic [31:0]        req_sector,
    input  logic [COUNT_W-1:0] req_count,
    output logic               req_busy,
    output logic               req_done,
    output logic               rd_start,
    output logic [31:0]        rd_sector,
    input  logic               rd_busy,
    input  logic               rd_done,
    input  logic               rd_outen,
    input  logic [8:0]         rd_outaddr,
    input  logic [7:0]         rd_outbyte,
    output logic               m_valid,
    output logic [7:0]         m_data,
    output logic               m_last,
    input  logic               m_ready
);
    fill_state_t  r_fstate, w_fstate_nxt;
    drain_state_t r_dstate, w_dstate_nxt;

    logic               r_busy, r_done, r_rd_start;
    logic [31:0]        r_sector;
    logic [COUNT_W-1:0] r_remaining, r_drain_left;
    logic [1:0]         r_full;
    logic               r_fill, r_drain;
    logic [8:0]         r_rd_addr;
    logic               r_rd_end;
    logic               r_inf, r_inf_eos, r_inf_last;
    skid_entry_t        r_q [2];
    logic [1:0]         r_q_cnt;

    logic        w_accept, w_issue, w_fill_done, w_we;
    logic        w_pop, w_release, w_final, w_rd_en, w_space;
    logic [1:0]  w_occ;
    logic [7:0]  w_rdata;
    skid_entry_t w_new;

    assign w_accept    = req_start & ~r_busy;
    assign w_fill_done = (r_fstate == F_WAIT) & rd_done;
    assign w_we        = (r_fstate == F_WAIT) & rd_outen;
    assign m_valid     = (r_q_cnt != 2'd0);
    assign w_pop       = m_valid & m_ready;
    assign w_release   = w_pop & r_q[0].eos;
    assign w_final     = w_pop & r_q[0].last;
    // Occupancy after this cycle's pop, counting the read still in the RAM pipe.
    assign w_occ       = r_q_cnt + {1'b0, r_inf} - {1'b0, w_pop};
    assign w_space     = (w_occ < 2'd2);
    assign w_new       = '{data: w_rdata, eos: r_inf_eos, last: r_inf_last};

    sd_bank_ram u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr ({r_fill, rd_outaddr}),
        .i_wdata (rd_outbyte),
        .i_re    (w_rd_en),
        .i_raddr ({r_drain, r_rd_addr}),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_fstate_nxt = r_fstate;
        w_issue      = 1'b0;
        case (r_fstate)
            F_IDLE:  if (w_accept && req_count != '0) w_fstate_nxt = F_ISSUE;
            F_ISSUE: if (r_remaining != '0 && !rd_busy && !r_full[r_fill]) begin
                         w_issue      = 1'b1;
                         w_fstate_nxt = F_WAIT;
                     end
            F_WAIT:  if (rd_done)
                         w_fstate_nxt = (r_remaining == COUNT_W'(1)) ? F_IDLE : F_ISSUE;
            default: w_fstate_nxt = F_IDLE;
        endcase
    end

    // Reading may begin in the same cycle the bank is seen full, saving a cycle of latency.
    always_comb begin
        w_dstate_nxt = r_dstate;
        w_rd_en      = 1'b0;
        case (r_dstate)
            D_IDLE:  if (r_full[r_drain]) begin
                         w_dstate_nxt = D_RUN;
                         w_rd_en      = ~r_rd_end & w_space;
                     end
            D_RUN:   begin
                         w_rd_en = ~r_rd_end & w_space;
                         if (w_release) w_dstate_nxt = D_IDLE;
                     end
            default: w_dstate_nxt = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fstate     <= F_IDLE;
            r_dstate     <= D_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_start   <= 1'b0;
            r_sector     <= '0;
            r_remaining  <= '0;
            r_drain_left <= '0;
            r_full       <= '0;
            r_fill       <= 1'b0;
            r_drain      <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_end     <= 1'b0;
            r_inf        <= 1'b0;
            r_inf_eos    <= 1'b0;
            r_inf_last   <= 1'b0;
            r_q[0]       <= '0;
            r_q[1]       <= '0;
            r_q_cnt      <= '0;
        end else begin
            r_fstate   <= w_fstate_nxt;
            r_dstate   <= w_dstate_nxt;
            r_rd_start <= w_issue;
            r_done     <= 1'b0;

            if (w_accept) begin
                if (req_count == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_busy       <= 1'b1;
                    r_sector     <= req_sector;
                    r_remaining  <= req_count;
                    r_drain_left <= req_count;
                end
            end

            if (w_fill_done) begin
                r_full[r_fill] <= 1'b1;
                r_fill         <= ~r_fill;
                r_sector       <= r_sector + 32'd1;
                r_remaining    <= r_remaining - COUNT_W'(1);
            end

            if (w_release) begin
                r_full[r_drain] <= 1'b0;
                r_drain         <= ~r_drain;
                r_drain_left    <= r_drain_left - COUNT_W'(1);
                r_rd_end        <= 1'b0;
            end

            if (w_final) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end

            // Address wraps to 0 after 511, ready for the next bank.
            if (w_rd_en) begin
                r_rd_addr  <= r_rd_addr + 9'd1;
                r_inf_eos  <= (r_rd_addr == LAST_ADDR);
                r_inf_last <= (r_rd_addr == LAST_ADDR) && (r_drain_left == COUNT_W'(1));
                if (r_rd_addr == LAST_ADDR) r_rd_end <= 1'b1;
            end
            r_inf <= w_rd_en;

            if (w_pop) begin
                r_q[0] <= r_q[1];
                if (r_inf) begin
                    if (r_q_cnt == 2'd1) r_q[0] <= w_new;
                    else                 r_q[1] <= w_new;
                end
            end else if (r_inf) begin
                if (r_q_cnt == 2'd0) r_q[0] <= w_new;
                else                 r_q[1] <= w_new;
            end
            r_q_cnt <= r_q_cnt + {1'b0, r_inf} - {1'b0, w_pop};
        end
    end

    assign req_busy  = r_busy;
    assign req_done  = r_done;
    assign rd_start  = r_rd_start;
    assign rd_sector = r_sector;
    assign m_data    = r_q[0].data;
    assign m_last    = r_q[0].last & m_valid;
endmodule
